// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-setting controller:
// FSM states, field-select encodings and BCD field limits.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  localparam logic [1:0] FS_NONE = 2'b00;
  localparam logic [1:0] FS_HR   = 2'b01;
  localparam logic [1:0] FS_MIN  = 2'b10;
  localparam logic [1:0] FS_SEC  = 2'b11;

  localparam logic [3:0] HR_MAX_M = 4'd2;
  localparam logic [3:0] HR_MAX_L = 4'd3;
  localparam logic [3:0] MS_MAX_M = 4'd5;
  localparam logic [3:0] MS_MAX_L = 4'd9;

endpackage

// File: rtl/rtc_bcd_inc.sv
// Two-digit BCD incrementer with wrap to 00 at or above the field maximum;
// a captured value with a non-decimal low digit also wraps to 00.
module rtc_bcd_inc
  import rtc_pkg::*;
#(
  parameter logic [3:0] MAX_M = MS_MAX_M,
  parameter logic [3:0] MAX_L = MS_MAX_L
) (
  input  logic [3:0] i_m,
  input  logic [3:0] i_l,
  output logic [3:0] o_m,
  output logic [3:0] o_l
);

  logic w_wrap;

  // Next BCD value of the field
  always_comb begin
    w_wrap = ({i_m, i_l} >= {MAX_M, MAX_L}) || (i_l > 4'd9);
    if (w_wrap) begin
      o_m = 4'd0;
      o_l = 4'd0;
    end else if (i_l == 4'd9) begin
      o_m = i_m + 4'd1;
      o_l = 4'd0;
    end else begin
      o_m = i_m;
      o_l = i_l + 4'd1;
    end
  end

endmodule

// File: rtl/rtc_set_ctrl.sv
// RTC time-setting controller: button edge detect, edit FSM, shadow time
// registers with BCD stepping, tick gating, commit load pulse and blink.
module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int BLINK_TICKS = 50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick_in,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  input  logic [3:0] i_cur_hrm,
  input  logic [3:0] i_cur_hrl,
  input  logic [3:0] i_cur_minm,
  input  logic [3:0] i_cur_minl,
  input  logic [3:0] i_cur_secm,
  input  logic [3:0] i_cur_secl,
  output logic       o_tick_out,
  output logic       o_load,
  output logic [3:0] o_ld_hrm,
  output logic [3:0] o_ld_hrl,
  output logic [3:0] o_ld_minm,
  output logic [3:0] o_ld_minl,
  output logic [3:0] o_ld_secm,
  output logic [3:0] o_ld_secl,
  output logic       o_set_active,
  output logic [1:0] o_field_sel,
  output logic       o_blink
);

  localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TICKS - 1);

  logic             r_mode_prev, r_inc_prev;
  logic             w_mode_edge, w_inc_edge;
  state_t           r_state, w_state_nxt;
  logic             w_capture, w_inc_hr, w_inc_min, w_inc_sec;
  logic             w_set_active;
  logic [3:0]       r_hrm, r_hrl, r_minm, r_minl, r_secm, r_secl;
  logic [3:0]       w_hrm_inc, w_hrl_inc, w_minm_inc, w_minl_inc, w_secm_inc, w_secl_inc;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink;

  assign w_mode_edge = i_btn_mode & ~r_mode_prev;
  assign w_inc_edge  = i_btn_inc & ~r_inc_prev;

  // Previous button levels; reset high so a button held through reset is not an edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode_prev <= 1'b1;
      r_inc_prev  <= 1'b1;
    end else begin
      r_mode_prev <= i_btn_mode;
      r_inc_prev  <= i_btn_inc;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and shadow update strobes; a mode edge always beats an inc edge
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_inc_hr    = 1'b0;
    w_inc_min   = 1'b0;
    w_inc_sec   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mode_edge) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_SET_HR;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_SET_HR: begin
        if (w_mode_edge) begin
          w_state_nxt = ST_SET_MIN;
        end else if (w_inc_edge) begin
          w_inc_hr = 1'b1;
        end else begin
          w_state_nxt = ST_SET_HR;
        end
      end
      ST_SET_MIN: begin
        if (w_mode_edge) begin
          w_state_nxt = ST_SET_SEC;
        end else if (w_inc_edge) begin
          w_inc_min = 1'b1;
        end else begin
          w_state_nxt = ST_SET_MIN;
        end
      end
      ST_SET_SEC: begin
        if (w_mode_edge) begin
          w_state_nxt = ST_COMMIT;
        end else if (w_inc_edge) begin
          w_inc_sec = 1'b1;
        end else begin
          w_state_nxt = ST_SET_SEC;
        end
      end
      ST_COMMIT: w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  rtc_bcd_inc #(.MAX_M(HR_MAX_M), .MAX_L(HR_MAX_L)) u_inc_hr (
    .i_m(r_hrm), .i_l(r_hrl), .o_m(w_hrm_inc), .o_l(w_hrl_inc)
  );
  rtc_bcd_inc #(.MAX_M(MS_MAX_M), .MAX_L(MS_MAX_L)) u_inc_min (
    .i_m(r_minm), .i_l(r_minl), .o_m(w_minm_inc), .o_l(w_minl_inc)
  );
  rtc_bcd_inc #(.MAX_M(MS_MAX_M), .MAX_L(MS_MAX_L)) u_inc_sec (
    .i_m(r_secm), .i_l(r_secl), .o_m(w_secm_inc), .o_l(w_secl_inc)
  );

  // Shadow time: capture live time on entry to edit, then step the selected field
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {r_hrm, r_hrl, r_minm, r_minl, r_secm, r_secl} <= 24'h000000;
    end else if (w_capture) begin
      {r_hrm, r_hrl, r_minm, r_minl, r_secm, r_secl} <=
        {i_cur_hrm, i_cur_hrl, i_cur_minm, i_cur_minl, i_cur_secm, i_cur_secl};
    end else if (w_inc_hr) begin
      {r_hrm, r_hrl} <= {w_hrm_inc, w_hrl_inc};
    end else if (w_inc_min) begin
      {r_minm, r_minl} <= {w_minm_inc, w_minl_inc};
    end else if (w_inc_sec) begin
      {r_secm, r_secl} <= {w_secm_inc, w_secl_inc};
    end
  end

  assign w_set_active = (r_state == ST_SET_HR) || (r_state == ST_SET_MIN) ||
                        (r_state == ST_SET_SEC);

  // Blink phase: restarts visible on every state change
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_state_nxt != r_state) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_set_active && i_tick_in) begin
      if (r_blink_cnt == CNT_LAST) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  // Field select decoded from the state register
  always_comb begin
    o_field_sel = FS_NONE;
    case (r_state)
      ST_SET_HR:  o_field_sel = FS_HR;
      ST_SET_MIN: o_field_sel = FS_MIN;
      ST_SET_SEC: o_field_sel = FS_SEC;
      default:    o_field_sel = FS_NONE;
    endcase
  end

  assign o_tick_out   = i_tick_in & (r_state == ST_RUN);
  assign o_load       = (r_state == ST_COMMIT);
  assign o_set_active = w_set_active;
  assign o_blink      = r_blink;
  assign o_ld_hrm     = r_hrm;
  assign o_ld_hrl     = r_hrl;
  assign o_ld_minm    = r_minm;
  assign o_ld_minl    = r_minl;
  assign o_ld_secm    = r_secm;
  assign o_ld_secl    = r_secl;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Self-checking bench for rtc_set_ctrl: directed edit scenarios plus random
// buttons/ticks/time, checked against a field-level model and a commit scoreboard.
module tb_rtc_set_ctrl;

  localparam int BT = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick_in = 1'b0;
  logic       tick_en = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] cur_hrm = 4'd0, cur_hrl = 4'd0, cur_minm = 4'd0;
  logic [3:0] cur_minl = 4'd0, cur_secm = 4'd0, cur_secl = 4'd0;
  logic       o_tick_out, o_load, o_set_active, o_blink;
  logic [1:0] o_field_sel;
  logic [3:0] o_ld_hrm, o_ld_hrl, o_ld_minm, o_ld_minl, o_ld_secm, o_ld_secl;

  int checks = 0;
  int errors = 0;

  rtc_set_ctrl #(.BLINK_TICKS(BT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick_in(tick_in),
    .i_btn_mode(btn_mode), .i_btn_inc(btn_inc),
    .i_cur_hrm(cur_hrm), .i_cur_hrl(cur_hrl), .i_cur_minm(cur_minm),
    .i_cur_minl(cur_minl), .i_cur_secm(cur_secm), .i_cur_secl(cur_secl),
    .o_tick_out(o_tick_out), .o_load(o_load),
    .o_ld_hrm(o_ld_hrm), .o_ld_hrl(o_ld_hrl), .o_ld_minm(o_ld_minm),
    .o_ld_minl(o_ld_minl), .o_ld_secm(o_ld_secm), .o_ld_secl(o_ld_secl),
    .o_set_active(o_set_active), .o_field_sel(o_field_sel), .o_blink(o_blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reference model: mode 0=run, 1=hours, 2=minutes, 3=seconds, 4=commit
  int   m_st = 0;
  int   hm = 0, hl = 0, mm = 0, ml = 0, sm = 0, sl = 0;
  bit   pm = 1'b1, pi = 1'b1;
  int   bc = 0;
  bit   bl = 1'b0;
  logic [23:0] exp_q[$];

  function automatic int bcd_next(input int m, input int l, input int maxv);
    if (m > 9 || l > 9 || (m * 10 + l) >= maxv) return 0;
    return m * 10 + l + 1;
  endfunction

  function automatic logic [23:0] model_time();
    return {4'(hm), 4'(hl), 4'(mm), 4'(ml), 4'(sm), 4'(sl)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int  nst, v;
    bit  me, ie;
    if (!rst_n) begin
      m_st = 0;
      hm = 0; hl = 0; mm = 0; ml = 0; sm = 0; sl = 0;
      pm = 1'b1; pi = 1'b1; bc = 0; bl = 1'b0;
      exp_q.delete();
    end else begin
      me = btn_mode && !pm;
      ie = btn_inc && !pi;
      pm = btn_mode;
      pi = btn_inc;
      nst = m_st;
      if (m_st == 0) begin
        if (me) begin
          hm = int'(cur_hrm);  hl = int'(cur_hrl);
          mm = int'(cur_minm); ml = int'(cur_minl);
          sm = int'(cur_secm); sl = int'(cur_secl);
          nst = 1;
        end
      end else if (m_st == 4) begin
        nst = 0;
      end else if (me) begin
        nst = m_st + 1;
      end else if (ie) begin
        if (m_st == 1) begin v = bcd_next(hm, hl, 23); hm = v / 10; hl = v % 10; end
        if (m_st == 2) begin v = bcd_next(mm, ml, 59); mm = v / 10; ml = v % 10; end
        if (m_st == 3) begin v = bcd_next(sm, sl, 59); sm = v / 10; sl = v % 10; end
      end
      if (nst != m_st) begin
        bc = 0;
        bl = 1'b0;
      end else if (m_st >= 1 && m_st <= 3 && tick_in) begin
        bc++;
        if (bc == BT) begin
          bc = 0;
          bl = !bl;
        end
      end
      if (nst == 4) exp_q.push_back(model_time());
      m_st = nst;
    end
  end

  // Monitor: per-cycle output comparison and commit scoreboard on load
  always @(negedge clk) begin
    chk("tick_out", o_tick_out, tick_in && (m_st == 0));
    chk("load", o_load, m_st == 4);
    chk("set_active", o_set_active, m_st >= 1 && m_st <= 3);
    chk("field_sel", o_field_sel, (m_st >= 1 && m_st <= 3) ? m_st : 0);
    chk("blink", o_blink, bl);
    chk("shadow", {o_ld_hrm, o_ld_hrl, o_ld_minm, o_ld_minl, o_ld_secm, o_ld_secl},
        model_time());
    if (o_load) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit_unexpected actual=load required=no_load");
      end else begin
        chk("commit_value", {o_ld_hrm, o_ld_hrl, o_ld_minm, o_ld_minl, o_ld_secm, o_ld_secl},
            exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #2;
    tick_in = tick_en && (($urandom % 4) == 0);
  end

  task automatic press_mode();
    btn_mode = 1'b1; cyc();
    btn_mode = 1'b0; cyc();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; cyc();
    btn_inc = 1'b0; cyc();
  endtask

  function automatic logic [23:0] ld_all();
    return {o_ld_hrm, o_ld_hrl, o_ld_minm, o_ld_minl, o_ld_secm, o_ld_secl};
  endfunction

  function automatic logic [3:0] rnd_digit();
    return (($urandom % 8) == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
  endfunction

  initial begin
    bit seen;
    // Reset with mode held high through release
    rst_n = 1'b0;
    btn_mode = 1'b1;
    {cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl} = 24'h123456;
    repeat (3) cyc();
    chk("reset_shadow", ld_all(), 24'h000000);
    chk("reset_load", o_load, 1'b0);
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("held_no_edge", o_set_active, 1'b0);
    btn_mode = 1'b0;
    cyc();

    // Capture 12:34:56 and step hours 12 -> 22 -> 23 -> 00 -> 01
    press_mode();
    chk("capture_shadow", ld_all(), 24'h123456);
    chk("capture_field", o_field_sel, 2'b01);
    repeat (10) press_inc();
    chk("hours_22", ld_all(), 24'h223456);
    press_inc();
    chk("hours_23", ld_all(), 24'h233456);
    press_inc();
    chk("hours_wrap", ld_all(), 24'h003456);
    press_inc();
    chk("hours_01", ld_all(), 24'h013456);

    // Minutes 34 -> 59 -> 00, seconds 56 -> 59
    press_mode();
    repeat (25) press_inc();
    chk("min_59", ld_all(), 24'h015956);
    press_inc();
    chk("min_wrap", ld_all(), 24'h010056);
    press_mode();
    repeat (3) press_inc();
    chk("sec_59", ld_all(), 24'h010059);

    // Commit: one load cycle with 01:00:59
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (o_load) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    chk("commit_seen", seen, 1'b1);
    chk("commit_ld", ld_all(), 24'h010059);
    cyc();
    chk("commit_once", o_load, 1'b0);
    chk("commit_run", o_set_active, 1'b0);
    repeat (5) cyc();

    // Simultaneous mode and inc edges in SET_MIN
    {cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl} = 24'h084730;
    press_mode();
    press_mode();
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    cyc();
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    chk("both_field", o_field_sel, 2'b11);
    chk("both_min_kept", ld_all(), 24'h084730);
    chk("both_blink0", o_blink, 1'b0);
    repeat (400) cyc();

    // Reset during SET_SEC
    rst_n = 1'b0;
    #1;
    chk("midreset_active", o_set_active, 1'b0);
    chk("midreset_shadow", ld_all(), 24'h000000);
    chk("midreset_load", o_load, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Random phase
    for (int n = 0; n < 4000; n++) begin
      if ((n % 50) == 0) begin
        cur_hrm = rnd_digit(); cur_hrl = rnd_digit();
        cur_minm = rnd_digit(); cur_minl = rnd_digit();
        cur_secm = rnd_digit(); cur_secl = rnd_digit();
      end
      btn_mode = (($urandom % 10) == 0);
      btn_inc = (($urandom % 3) == 0);
      rst_n = (($urandom % 600) != 0);
      cyc();
    end
    rst_n = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (4) cyc();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
